// File: rtl/toy_bpu_tage_mem_arb_if.sv
// Port bundle for the TAGE tagged-table memory arbiter: predict/update
// request streams, memory request/ack and sweep status.
interface toy_bpu_tage_mem_arb_if #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 16
);
  logic              pred_vld;
  logic              pred_rdy;
  logic [IDX_W-1:0]  pred_idx;
  logic              pred_resp_vld;
  logic [DATA_W-1:0] pred_resp_data;
  logic              upd_vld;
  logic              upd_rdy;
  logic [IDX_W-1:0]  upd_idx;
  logic [DATA_W-1:0] upd_wdata;
  logic              flush;
  logic              mem_req_vld;
  logic              mem_req_wren;
  logic [IDX_W-1:0]  mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [DATA_W-1:0] mem_ack_rdata;
  logic              sweep_busy;

  modport master (
    output pred_vld, pred_idx, upd_vld, upd_idx, upd_wdata, flush, mem_ack_rdata,
    input  pred_rdy, pred_resp_vld, pred_resp_data, upd_rdy,
           mem_req_vld, mem_req_wren, mem_req_addr, mem_req_wdata, sweep_busy
  );

  modport slave (
    input  pred_vld, pred_idx, upd_vld, upd_idx, upd_wdata, flush, mem_ack_rdata,
    output pred_rdy, pred_resp_vld, pred_resp_data, upd_rdy,
           mem_req_vld, mem_req_wren, mem_req_addr, mem_req_wdata, sweep_busy
  );
endinterface

// File: rtl/toy_bpu_tage_mem_arb.sv
// Single-port scheduler for one TAGE tagged table: predict reads, FIFO-buffered
// update writes and a periodic U-field aging sweep. Define TAGE_MEM_ARB_STARVE_EN
// to enable the forced update write after STARVE_MAX stalled cycles.
module toy_bpu_tage_mem_arb #(
  parameter int IDX_W        = 8,
  parameter int DATA_W       = 16,
  parameter int U_W          = 2,
  parameter int UPD_DEPTH    = 4,
  parameter int STARVE_MAX   = 8,
  parameter int CLR_PERIOD_W = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  toy_bpu_tage_mem_arb_if.slave  bus
);
  localparam int AW = $clog2(UPD_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWP_RD = 2'd1;
  localparam logic [1:0] ST_SWP_WR = 2'd2;

  if (UPD_DEPTH < 2 || (UPD_DEPTH & (UPD_DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("toy_bpu_tage_mem_arb: UPD_DEPTH must be a power of 2 >= 2, STARVE_MAX >= 1");
  end

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        sweep_idx_q, sweep_idx_d;
  logic                    sweep_pend_q, sweep_pend_d;
  logic [CLR_PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    pred_resp_vld_q, pred_resp_vld_d;

  logic [IDX_W-1:0]        fifo_idx_q  [UPD_DEPTH];
  logic [DATA_W-1:0]       fifo_data_q [UPD_DEPTH];

  logic fifo_empty, fifo_full, push, pop, forced, period_wrap;
  logic pred_go, upd_go, swp_wr_go, swp_rd_go;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push        = bus.upd_vld && !fifo_full;
  assign pop         = upd_go;
  assign period_wrap = &period_cnt_q;

`ifdef TAGE_MEM_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SC_W'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign forced = !fifo_empty && (starve_cnt_q == SC_W'(STARVE_MAX));
`else
  assign forced = 1'b0;
`endif

  // Port arbitration: sweep write > forced update > predict > update > sweep read.
  always_comb begin
    swp_wr_go = (state_q == ST_SWP_WR);
    pred_go   = bus.pred_vld && !swp_wr_go && !forced;
    upd_go    = !fifo_empty && !swp_wr_go && (forced || !bus.pred_vld);
    swp_rd_go = (state_q == ST_SWP_RD) && !bus.pred_vld && fifo_empty;

    bus.mem_req_vld   = 1'b0;
    bus.mem_req_wren  = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    if (swp_wr_go) begin
      bus.mem_req_vld   = 1'b1;
      bus.mem_req_wren  = 1'b1;
      bus.mem_req_addr  = sweep_idx_q;
      bus.mem_req_wdata = {bus.mem_ack_rdata[DATA_W-1:U_W], {U_W{1'b0}}};
    end else if (pred_go) begin
      bus.mem_req_vld   = 1'b1;
      bus.mem_req_addr  = bus.pred_idx;
    end else if (upd_go) begin
      bus.mem_req_vld   = 1'b1;
      bus.mem_req_wren  = 1'b1;
      bus.mem_req_addr  = fifo_idx_q[rd_ptr_q[AW-1:0]];
      bus.mem_req_wdata = fifo_data_q[rd_ptr_q[AW-1:0]];
    end else if (swp_rd_go) begin
      bus.mem_req_vld   = 1'b1;
      bus.mem_req_addr  = sweep_idx_q;
    end
  end

  // Sweep sequencer; a period wrap seen mid-sweep is remembered in sweep_pend.
  always_comb begin
    state_d      = state_q;
    sweep_idx_d  = sweep_idx_q;
    sweep_pend_d = sweep_pend_q;
    period_cnt_d = period_cnt_q + CLR_PERIOD_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (period_wrap || sweep_pend_q) begin
          state_d      = ST_SWP_RD;
          sweep_pend_d = 1'b0;
        end
      end
      ST_SWP_RD: begin
        if (swp_rd_go) state_d = ST_SWP_WR;
        if (period_wrap) sweep_pend_d = 1'b1;
      end
      ST_SWP_WR: begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        state_d     = (sweep_idx_q == {IDX_W{1'b1}}) ? ST_IDLE : ST_SWP_RD;
        if (period_wrap) sweep_pend_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d        = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    pred_resp_vld_d = pred_go;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      sweep_idx_q     <= '0;
      sweep_pend_q    <= 1'b0;
      period_cnt_q    <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      pred_resp_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sweep_idx_q     <= sweep_idx_d;
      sweep_pend_q    <= sweep_pend_d;
      period_cnt_q    <= period_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      pred_resp_vld_q <= pred_resp_vld_d;
    end
  end

  // FIFO storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q[AW-1:0]]  <= bus.upd_idx;
      fifo_data_q[wr_ptr_q[AW-1:0]] <= bus.upd_wdata;
    end
  end

  assign bus.pred_rdy       = pred_go;
  assign bus.pred_resp_vld  = pred_resp_vld_q && !bus.flush;
  assign bus.pred_resp_data = bus.mem_ack_rdata;
  assign bus.upd_rdy        = !fifo_full;
  assign bus.sweep_busy     = (state_q != ST_IDLE);
endmodule
